// File: rtl/cic_rate_ctrl.sv
// Run-time decimation sequencer for one cic instance: switches rate on an output
// boundary, starves the cic for a guard interval, then discards its settling outputs.
module cic_rate_ctrl #(
  parameter int STAGES             = 5,
  parameter int MIN_DECIMATION     = 2,
  parameter int MAX_DECIMATION     = 40,
  parameter int DEFAULT_DECIMATION = 40,
  parameter int HOLD_CYCLES        = 4,
  parameter int FLUSH_OUTPUTS      = STAGES,
  parameter int DW                 = $clog2(MAX_DECIMATION) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rate_req,
  input  logic [DW-1:0] rate_in,
  input  logic          src_strobe,
  output logic          cic_in_strobe,
  input  logic          cic_out_strobe,
  output logic          out_valid,
  output logic [DW-1:0] decimation,
  output logic          busy,
  output logic          rate_ack,
  output logic          rate_err
);

  localparam logic [DW-1:0] MIN_D     = DW'(MIN_DECIMATION);
  localparam logic [DW-1:0] MAX_D     = DW'(MAX_DECIMATION);
  localparam logic [DW-1:0] DEF_D     = DW'(DEFAULT_DECIMATION);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]    FLUSH_LAST = 8'((FLUSH_OUTPUTS > 0) ? (FLUSH_OUTPUTS - 1) : 0);
  localparam bit            NO_FLUSH  = (FLUSH_OUTPUTS == 0);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t        state_q;
  logic [DW-1:0] pend_q;
  logic [DW-1:0] dec_q;
  logic [7:0]    hold_cnt_q;
  logic [7:0]    flush_cnt_q;
  logic          busy_q;
  logic          ack_q;
  logic          err_q;
  logic          err_defer_q;

  logic req_in_range;
  logic req_same;
  logic hold_done;
  logic flush_done;
  logic err_any;
  logic ack_d;
  logic err_d;
  logic err_defer_d;

  assign cic_in_strobe = reset_n & src_strobe & (state_q != S_HOLD);
  assign out_valid     = reset_n & cic_out_strobe & ((state_q == S_RUN) | (state_q == S_DRAIN));
  assign decimation    = dec_q;
  assign busy          = busy_q;
  assign rate_ack      = ack_q;
  assign rate_err      = err_q;

  always_comb begin
    req_in_range = (rate_in >= MIN_D) && (rate_in <= MAX_D);
    req_same     = (rate_in == dec_q);
    hold_done    = (state_q == S_HOLD) && (hold_cnt_q == HOLD_LAST);
    flush_done   = (state_q == S_FLUSH) && cic_out_strobe && (flush_cnt_q == FLUSH_LAST);
    ack_d        = (hold_done && NO_FLUSH) || flush_done ||
                   ((state_q == S_RUN) && rate_req && req_in_range && req_same);
    err_any      = err_defer_q || (rate_req && ((state_q != S_RUN) || !req_in_range));
    // A reject that lands on a completion cycle is pushed back one clock so the
    // two pulses never overlap.
    err_d        = err_any && !ack_d;
    err_defer_d  = err_any && ack_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      pend_q      <= DEF_D;
      dec_q       <= DEF_D;
      hold_cnt_q  <= 8'd0;
      flush_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      err_defer_q <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      err_q       <= err_d;
      err_defer_q <= err_defer_d;
      case (state_q)
        S_RUN: begin
          if (rate_req && req_in_range && !req_same) begin
            pend_q  <= rate_in;
            state_q <= S_DRAIN;
            busy_q  <= 1'b1;
          end
        end
        S_DRAIN: begin
          // This strobe is the last old-rate sample; it still passes downstream.
          if (cic_out_strobe) begin
            dec_q      <= pend_q;
            hold_cnt_q <= 8'd0;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          hold_cnt_q <= hold_cnt_q + 8'd1;
          if (hold_done) begin
            flush_cnt_q <= 8'd0;
            if (NO_FLUSH) begin
              state_q <= S_RUN;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (cic_out_strobe) begin
            flush_cnt_q <= flush_cnt_q + 8'd1;
            if (flush_done) begin
              state_q <= S_RUN;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Bench for cic_rate_ctrl: directed scenarios plus a randomized trace checked against
// an event-index reference model; a second instance is built with no flush stage.
module tb_cic_rate_ctrl;

  localparam int DW   = 7;
  localparam int NMAX = 2048;
  localparam int H    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          src = 1'b0;
  logic          cout = 1'b0;
  logic          req = 1'b0;
  logic [DW-1:0] rin = '0;

  logic          in0, ov0, busy0, ack0, err0;
  logic [DW-1:0] dec0;
  logic          in1, ov1, busy1, ack1, err1;
  logic [DW-1:0] dec1;

  cic_rate_ctrl #(.FLUSH_OUTPUTS(5)) u_dut0 (
    .clock(clk), .reset_n(reset_n), .rate_req(req), .rate_in(rin),
    .src_strobe(src), .cic_in_strobe(in0), .cic_out_strobe(cout), .out_valid(ov0),
    .decimation(dec0), .busy(busy0), .rate_ack(ack0), .rate_err(err0)
  );

  cic_rate_ctrl #(.FLUSH_OUTPUTS(0)) u_dut1 (
    .clock(clk), .reset_n(reset_n), .rate_req(req), .rate_in(rin),
    .src_strobe(src), .cic_in_strobe(in1), .cic_out_strobe(cout), .out_valid(ov1),
    .decimation(dec1), .busy(busy1), .rate_ack(ack1), .rate_err(err1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic          s_in [2], s_ov [2], s_busy [2], s_ack [2], s_err [2];
  logic [DW-1:0] s_dec [2];

  // stimulus trace, recorded outputs and reference expectations
  logic          t_src [NMAX], t_cout [NMAX], t_req [NMAX];
  logic [DW-1:0] t_rin [NMAX];
  logic          r_in [2][NMAX], r_ov [2][NMAX], r_busy [2][NMAX], r_ack [2][NMAX], r_err [2][NMAX];
  logic [DW-1:0] r_dec [2][NMAX];
  logic          e_in_en [NMAX], e_ov_en [NMAX], e_busy [NMAX], e_ack [NMAX], e_err [NMAX];
  logic [DW-1:0] e_dec [NMAX];

  task automatic step(input logic s, input logic c, input logic q, input logic [DW-1:0] r);
    @(negedge clk);
    src = s; cout = c; req = q; rin = r;
    #1;
    s_in[0] = in0; s_ov[0] = ov0; s_dec[0] = dec0; s_busy[0] = busy0; s_ack[0] = ack0; s_err[0] = err0;
    s_in[1] = in1; s_ov[1] = ov1; s_dec[1] = dec1; s_busy[1] = busy1; s_ack[1] = ack1; s_err[1] = err1;
  endtask

  task automatic record(input int i);
    for (int g = 0; g < 2; g++) begin
      r_in[g][i] = s_in[g]; r_ov[g][i] = s_ov[g]; r_dec[g][i] = s_dec[g];
      r_busy[g][i] = s_busy[g]; r_ack[g][i] = s_ack[g]; r_err[g][i] = s_err[g];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    src = 1'b0; cout = 1'b0; req = 1'b0; rin = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Expected behaviour derived from request positions and output-strobe positions:
  // a change drains to the next output strobe, blanks H clocks, then swallows F outputs.
  task automatic build_model(input int F, input int n);
    int lo, hi, cur, d, j, cnt;
    lo = 0; hi = -1; cur = 40;
    for (int i = 0; i < NMAX; i++) begin
      e_in_en[i] = 1'b1; e_ov_en[i] = 1'b1; e_dec[i] = 7'd40;
      e_busy[i] = 1'b0; e_ack[i] = 1'b0; e_err[i] = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      if (!t_req[k]) continue;
      if (k >= lo && k <= hi) e_err[k+1] = 1'b1;
      else if (int'(t_rin[k]) < 2 || int'(t_rin[k]) > 40) e_err[k+1] = 1'b1;
      else if (int'(t_rin[k]) == cur) e_ack[k+1] = 1'b1;
      else begin
        lo = k + 1; hi = NMAX - 1;
        d = k + 1;
        while (d < n && !t_cout[d]) d++;
        if (d < n) begin
          for (j = d + 1; j <= d + H && j < NMAX; j++) begin
            e_in_en[j] = 1'b0; e_ov_en[j] = 1'b0;
          end
          for (j = d + 1; j < NMAX; j++) e_dec[j] = t_rin[k];
          cur = int'(t_rin[k]);
          if (F == 0) hi = d + H;
          else begin
            cnt = 0; j = d + H + 1;
            while (j < n && cnt < F) begin
              e_ov_en[j] = 1'b0;
              if (t_cout[j]) begin
                cnt++;
                if (cnt == F) hi = j;
              end
              j++;
            end
          end
          if (hi < NMAX - 1) e_ack[hi+1] = 1'b1;
        end
        for (j = lo; j <= hi && j < NMAX; j++) e_busy[j] = 1'b1;
      end
    end
    for (int i = 0; i < NMAX - 1; i++)
      if (e_ack[i] && e_err[i]) begin e_err[i] = 1'b0; e_err[i+1] = 1'b1; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; src = 1'b1; cout = 1'b1; req = 1'b0;
    #1;
    n_checks++; if ({in0, ov0, in1, ov1} !== 4'b0000) begin n_fails++; $display("FAIL reset_gate got=%b exp=0000", {in0, ov0, in1, ov1}); end
    n_checks++; if (dec0 !== 7'd40) begin n_fails++; $display("FAIL reset_dec got=%0d exp=40", dec0); end
    n_checks++; if ({busy0, ack0, err0, busy1, ack1, err1} !== 6'b0) begin n_fails++; $display("FAIL reset_flags got=%b exp=000000", {busy0, ack0, err0, busy1, ack1, err1}); end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 7'd0);
    n_checks++; if ({s_in[0], s_ov[0]} !== 2'b11) begin n_fails++; $display("FAIL reset_release_pass got=%b exp=11", {s_in[0], s_ov[0]}); end
    n_checks++; if (s_dec[0] !== 7'd40 || s_busy[0] !== 1'b0) begin n_fails++; $display("FAIL reset_release_state got=dec%0d/busy%0b exp=dec40/busy0", s_dec[0], s_busy[0]); end
    $display("reset: done");
  endtask

  // Closed loop with a simple cic strobe model: one output per decimation accepted inputs.
  task automatic test_nominal();
    localparam int NN = 900, REQ = 200;
    int cic_cnt, d, a, nsup, acks, leak, f5, v[3], nv, j;
    logic cic_pend;
    do_reset();
    cic_cnt = 0; cic_pend = 1'b0;
    for (int i = 0; i < NN; i++) begin
      t_src[i] = (i % 4 == 0); t_cout[i] = cic_pend;
      step(t_src[i], t_cout[i], (i == REQ), 7'd10);
      record(i);
      cic_pend = 1'b0;
      if (s_in[0]) begin
        if (cic_cnt + 1 >= int'(s_dec[0])) begin cic_pend = 1'b1; cic_cnt = 0; end
        else cic_cnt++;
      end
    end
    n_checks++; if ({r_busy[0][REQ], r_busy[0][REQ+1]} !== 2'b01) begin n_fails++; $display("FAIL nominal_busy_rise got=%b exp=01", {r_busy[0][REQ], r_busy[0][REQ+1]}); end
    d = REQ + 1;
    while (d < NN && !t_cout[d]) d++;
    if (d + 10 >= NN) begin
      n_checks++; n_fails++; $display("FAIL nominal_no_drain_strobe got=none exp=strobe");
      return;
    end
    n_checks++; if (r_ov[0][d] !== 1'b1) begin n_fails++; $display("FAIL nominal_last_old_valid got=%0b exp=1", r_ov[0][d]); end
    n_checks++; if (r_dec[0][d] !== 7'd40 || r_dec[0][d+1] !== 7'd10) begin n_fails++; $display("FAIL nominal_dec_switch got=%0d->%0d exp=40->10", r_dec[0][d], r_dec[0][d+1]); end
    leak = 0;
    for (j = REQ; j < d + 80; j++)
      if (r_in[0][j] !== (t_src[j] && !(j > d && j <= d + H))) leak++;
    n_checks++; if (leak != 0) begin n_fails++; $display("FAIL nominal_hold_gate got=%0d bad cycles exp=0", leak); end
    nsup = 0; f5 = -1; j = d + 1;
    while (j < NN && !(t_cout[j] && r_ov[0][j] === 1'b1)) begin
      if (t_cout[j]) begin nsup++; if (nsup == 5) f5 = j; end
      j++;
    end
    n_checks++; if (nsup != 5) begin n_fails++; $display("FAIL nominal_suppressed got=%0d exp=5", nsup); end
    acks = 0; a = -1;
    for (j = REQ; j < NN; j++) if (r_ack[0][j]) begin acks++; a = j; end
    n_checks++; if (acks != 1 || a != f5 + 1) begin n_fails++; $display("FAIL nominal_ack got=%0d acks at %0d exp=1 at %0d", acks, a, f5 + 1); end
    if (a > 0) begin
      n_checks++; if ({r_busy[0][a-1], r_busy[0][a]} !== 2'b10) begin n_fails++; $display("FAIL nominal_busy_fall got=%b exp=10", {r_busy[0][a-1], r_busy[0][a]}); end
      nv = 0;
      for (j = a; j < NN && nv < 3; j++) if (r_ov[0][j]) begin v[nv] = j; nv++; end
      n_checks++; if (nv != 3 || v[1] - v[0] != 40 || v[2] - v[1] != 40) begin n_fails++; $display("FAIL nominal_new_rate got=%0d outputs gaps %0d,%0d exp=3 outputs gaps 40,40", nv, v[1] - v[0], v[2] - v[1]); end
    end
    $display("nominal: req@%0d drain@%0d ack@%0d suppressed=%0d", REQ, d, a, nsup);
  endtask

  task automatic test_reject_range();
    logic [DW-1:0] bad [4];
    bad[0] = 7'd1; bad[1] = 7'd41; bad[2] = 7'd0; bad[3] = 7'd127;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, bad[i]);
      n_checks++; if ({s_in[0], s_ov[0]} !== 2'b11) begin n_fails++; $display("FAIL reject_pass rate=%0d got=%b exp=11", bad[i], {s_in[0], s_ov[0]}); end
      step(1'b0, 1'b0, 1'b0, 7'd0);
      n_checks++; if ({s_err[0], s_ack[0], s_busy[0]} !== 3'b100) begin n_fails++; $display("FAIL reject_err rate=%0d got=err%0b/ack%0b/busy%0b exp=1/0/0", bad[i], s_err[0], s_ack[0], s_busy[0]); end
      step(1'b0, 1'b0, 1'b0, 7'd0);
      n_checks++; if (s_err[0] !== 1'b0 || s_dec[0] !== 7'd40 || s_busy[0] !== 1'b0) begin n_fails++; $display("FAIL reject_after rate=%0d got=err%0b/dec%0d/busy%0b exp=0/40/0", bad[i], s_err[0], s_dec[0], s_busy[0]); end
      $display("reject: rate=%0d", bad[i]);
    end
  endtask

  task automatic test_equal_rate();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 7'd40);
    n_checks++; if ({s_in[0], s_ov[0]} !== 2'b11) begin n_fails++; $display("FAIL equal_pass0 got=%b exp=11", {s_in[0], s_ov[0]}); end
    step(1'b1, 1'b1, 1'b0, 7'd0);
    n_checks++; if ({s_ack[0], s_err[0], s_busy[0]} !== 3'b100) begin n_fails++; $display("FAIL equal_ack got=ack%0b/err%0b/busy%0b exp=1/0/0", s_ack[0], s_err[0], s_busy[0]); end
    n_checks++; if ({s_in[0], s_ov[0]} !== 2'b11) begin n_fails++; $display("FAIL equal_pass1 got=%b exp=11", {s_in[0], s_ov[0]}); end
    step(1'b1, 1'b0, 1'b0, 7'd0);
    n_checks++; if ({s_ack[0], s_busy[0], s_in[0]} !== 3'b001) begin n_fails++; $display("FAIL equal_after got=ack%0b/busy%0b/in%0b exp=0/0/1", s_ack[0], s_busy[0], s_in[0]); end
    $display("equal: rate=40");
  endtask

  task automatic test_req_during_flush();
    int acks, ack_at, idx, gated;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 7'd7);
    step(1'b1, 1'b0, 1'b0, 7'd0);
    n_checks++; if ({s_busy[0], s_in[0]} !== 2'b11) begin n_fails++; $display("FAIL flushreq_drain got=busy%0b/in%0b exp=1/1", s_busy[0], s_in[0]); end
    step(1'b0, 1'b1, 1'b0, 7'd0);
    n_checks++; if (s_ov[0] !== 1'b1 || s_dec[0] !== 7'd40) begin n_fails++; $display("FAIL flushreq_last_old got=ov%0b/dec%0d exp=1/40", s_ov[0], s_dec[0]); end
    gated = 0;
    for (int i = 0; i < H; i++) begin
      step(1'b1, 1'b0, 1'b0, 7'd0);
      if (s_in[0] === 1'b0) gated++;
    end
    n_checks++; if (gated != H || s_dec[0] !== 7'd7) begin n_fails++; $display("FAIL flushreq_hold got=%0d gated/dec%0d exp=%0d/7", gated, s_dec[0], H); end
    step(1'b1, 1'b0, 1'b1, 7'd20);
    n_checks++; if (s_in[0] !== 1'b1) begin n_fails++; $display("FAIL flushreq_flush_pass got=%0b exp=1", s_in[0]); end
    step(1'b0, 1'b0, 1'b0, 7'd0);
    n_checks++; if (s_err[0] !== 1'b1) begin n_fails++; $display("FAIL flushreq_err got=%0b exp=1", s_err[0]); end
    acks = 0; ack_at = -1; idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 7'd0);
      n_checks++; if (s_ov[0] !== 1'b0) begin n_fails++; $display("FAIL flushreq_suppress n=%0d got=%0b exp=0", i, s_ov[0]); end
      if (s_ack[0]) begin acks++; ack_at = idx; end
      idx++;
      step(1'b0, 1'b0, 1'b0, 7'd0);
      if (s_ack[0]) begin acks++; ack_at = idx; end
      idx++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 7'd0);
      if (s_ack[0]) begin acks++; ack_at = idx; end
      idx++;
    end
    n_checks++; if (acks != 1 || ack_at != 9) begin n_fails++; $display("FAIL flushreq_ack got=%0d at %0d exp=1 at 9", acks, ack_at); end
    step(1'b0, 1'b1, 1'b0, 7'd0);
    n_checks++; if ({s_ov[0], s_busy[0]} !== 2'b10 || s_dec[0] !== 7'd7) begin n_fails++; $display("FAIL flushreq_final got=ov%0b/busy%0b/dec%0d exp=1/0/7", s_ov[0], s_busy[0], s_dec[0]); end
    $display("flushreq: acks=%0d final_dec=%0d", acks, s_dec[0]);
  endtask

  task automatic test_coincident();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 7'd12);
    n_checks++; if ({s_ov[0], s_in[0]} !== 2'b11) begin n_fails++; $display("FAIL coinc_valid got=%b exp=11", {s_ov[0], s_in[0]}); end
    step(1'b1, 1'b0, 1'b0, 7'd0);
    n_checks++; if (s_busy[0] !== 1'b1 || s_dec[0] !== 7'd40) begin n_fails++; $display("FAIL coinc_drain got=busy%0b/dec%0d exp=1/40", s_busy[0], s_dec[0]); end
    step(1'b1, 1'b0, 1'b0, 7'd0);
    n_checks++; if (s_dec[0] !== 7'd40 || s_in[0] !== 1'b1) begin n_fails++; $display("FAIL coinc_wait got=dec%0d/in%0b exp=40/1", s_dec[0], s_in[0]); end
    step(1'b1, 1'b1, 1'b0, 7'd0);
    n_checks++; if (s_ov[0] !== 1'b1 || s_dec[0] !== 7'd40) begin n_fails++; $display("FAIL coinc_last_old got=ov%0b/dec%0d exp=1/40", s_ov[0], s_dec[0]); end
    step(1'b1, 1'b0, 1'b0, 7'd0);
    n_checks++; if (s_dec[0] !== 7'd12 || s_in[0] !== 1'b0) begin n_fails++; $display("FAIL coinc_switch got=dec%0d/in%0b exp=12/0", s_dec[0], s_in[0]); end
    $display("coincident: dec=%0d", s_dec[0]);
  endtask

  task automatic test_reset_mid_change();
    int bad_in, pulses;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 7'd9);
    step(1'b0, 1'b1, 1'b0, 7'd0);
    step(1'b1, 1'b0, 1'b0, 7'd0);
    n_checks++; if (s_in[0] !== 1'b0) begin n_fails++; $display("FAIL midrst_in_hold got=%0b exp=0", s_in[0]); end
    #2;
    reset_n = 1'b0; src = 1'b1; cout = 1'b1;
    #1;
    n_checks++; if ({in0, ov0, busy0} !== 3'b000 || dec0 !== 7'd40) begin n_fails++; $display("FAIL midrst_async got=in%0b/ov%0b/busy%0b/dec%0d exp=0/0/0/40", in0, ov0, busy0, dec0); end
    @(negedge clk);
    reset_n = 1'b1;
    bad_in = 0; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(i[0], (i % 3 == 0), 1'b0, 7'd0);
      if (s_in[0] !== src || s_ov[0] !== cout || s_dec[0] !== 7'd40 || s_busy[0] !== 1'b0) bad_in++;
      if (s_ack[0] || s_err[0]) pulses++;
    end
    n_checks++; if (bad_in != 0) begin n_fails++; $display("FAIL midrst_after got=%0d bad cycles exp=0", bad_in); end
    n_checks++; if (pulses != 0) begin n_fails++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
    $display("midreset: bad=%0d pulses=%0d", bad_in, pulses);
  endtask

  task automatic test_flush0();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 7'd5);
    step(1'b0, 1'b0, 1'b0, 7'd0);
    step(1'b0, 1'b1, 1'b0, 7'd0);
    n_checks++; if (s_ov[1] !== 1'b1) begin n_fails++; $display("FAIL flush0_last_old got=%0b exp=1", s_ov[1]); end
    for (int i = 0; i < H; i++) begin
      step(1'b1, 1'b1, 1'b0, 7'd0);
      n_checks++; if ({s_in[1], s_ov[1], s_ack[1]} !== 3'b000) begin n_fails++; $display("FAIL flush0_hold n=%0d got=%b exp=000", i, {s_in[1], s_ov[1], s_ack[1]}); end
    end
    step(1'b1, 1'b1, 1'b0, 7'd0);
    n_checks++; if ({s_ack[1], s_ov[1], s_in[1], s_busy[1]} !== 4'b1110 || s_dec[1] !== 7'd5) begin n_fails++; $display("FAIL flush0_ack got=%b/dec%0d exp=1110/5", {s_ack[1], s_ov[1], s_in[1], s_busy[1]}, s_dec[1]); end
    step(1'b1, 1'b1, 1'b0, 7'd0);
    n_checks++; if ({s_ack[1], s_ov[1]} !== 2'b01) begin n_fails++; $display("FAIL flush0_after got=%b exp=01", {s_ack[1], s_ov[1]}); end
    $display("flush0: dec=%0d", s_dec[1]);
  endtask

  task automatic test_random();
    localparam int N = 1500;
    int nreq, fcount;
    do_reset();
    nreq = 0;
    for (int i = 0; i < N; i++) begin
      t_src[i]  = ($urandom_range(0, 2) == 0);
      t_cout[i] = ($urandom_range(0, 6) == 0);
      t_req[i]  = (i < N - 300) && ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: t_rin[i] = 7'($urandom_range(2, 40));
        1: t_rin[i] = 7'($urandom_range(0, 127));
        2: t_rin[i] = 7'd40;
        default: t_rin[i] = 7'($urandom_range(2, 12));
      endcase
      if (t_req[i]) nreq++;
    end
    for (int i = 0; i < N; i++) begin
      step(t_src[i], t_cout[i], t_req[i], t_rin[i]);
      record(i);
    end
    for (int g = 0; g < 2; g++) begin
      fcount = n_fails;
      build_model((g == 0) ? 5 : 0, N);
      for (int i = 0; i < N; i++) begin
        n_checks++; if (r_in[g][i] !== (t_src[i] & e_in_en[i])) begin n_fails++; if (n_fails < 30) $display("FAIL rnd%0d_in cyc=%0d got=%0b exp=%0b", g, i, r_in[g][i], t_src[i] & e_in_en[i]); end
        n_checks++; if (r_ov[g][i] !== (t_cout[i] & e_ov_en[i])) begin n_fails++; if (n_fails < 30) $display("FAIL rnd%0d_ov cyc=%0d got=%0b exp=%0b", g, i, r_ov[g][i], t_cout[i] & e_ov_en[i]); end
        n_checks++; if (r_dec[g][i] !== e_dec[i]) begin n_fails++; if (n_fails < 30) $display("FAIL rnd%0d_dec cyc=%0d got=%0d exp=%0d", g, i, r_dec[g][i], e_dec[i]); end
        n_checks++; if (r_busy[g][i] !== e_busy[i]) begin n_fails++; if (n_fails < 30) $display("FAIL rnd%0d_busy cyc=%0d got=%0b exp=%0b", g, i, r_busy[g][i], e_busy[i]); end
        n_checks++; if (r_ack[g][i] !== e_ack[i]) begin n_fails++; if (n_fails < 30) $display("FAIL rnd%0d_ack cyc=%0d got=%0b exp=%0b", g, i, r_ack[g][i], e_ack[i]); end
        n_checks++; if (r_err[g][i] !== e_err[i]) begin n_fails++; if (n_fails < 30) $display("FAIL rnd%0d_err cyc=%0d got=%0b exp=%0b", g, i, r_err[g][i], e_err[i]); end
      end
      $display("random: dut%0d requests=%0d new_failures=%0d", g, nreq, n_fails - fcount);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal();
    test_reject_range();
    test_equal_rate();
    test_req_during_flush();
    test_coincident();
    test_reset_mid_change();
    test_flush0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
